// File: rtl/out_display_pkg.sv
// out_display_pkg: shared definitions for the output-register display driver.
//   state_t        FSM states (IDLE, CONVERT, COMMIT)
//   BCD_DIGITS     number of BCD nibbles produced by the converter (0..255)
//   SEG_BLANK/MINUS special segment codes (gfedcba, active high)
//   seg_of_digit() BCD digit to seven-segment code; non-decimal codes blank
package out_display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   localparam int unsigned BCD_DIGITS = 3;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_MINUS = 7'h40;

   function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/out_display_if.sv
// out_display_if: output-register write port of out_display.
//   i_clke  clock enable qualifying i_load
//   i_load  output-register load strobe
//   i_data  value written to the output register
//   o_busy  conversion or pending value outstanding
// master drives the write (CPU side), slave is the display driver.
interface out_display_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  i_clke;
   logic                  i_load;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  o_busy;

   modport master (output i_clke, output i_load, output i_data, input o_busy);
   modport slave  (input i_clke, input i_load, input i_data, output o_busy);
endinterface

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial shift-add-3 (double dabble) binary to BCD converter.
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   i_start           load i_bin and begin DATA_WIDTH conversion steps
//   i_bin             binary value to convert
//   o_last            the final conversion step is taken at the next edge
//   o_done            result valid; pulses for one cycle after the last step
//   o_bcd             BCD result, BCD_DIGITS nibbles, ones in [3:0]
module bin2bcd_serial
   import out_display_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_start,
   input  logic [DATA_WIDTH-1:0]   i_bin,
   output logic                    o_last,
   output logic                    o_done,
   output logic [4*BCD_DIGITS-1:0] o_bcd
);
   localparam int unsigned   CW    = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] STEPS = CW'(DATA_WIDTH);

   logic [DATA_WIDTH-1:0]   shreg;
   logic [CW-1:0]           step;
   logic                    active;
   logic [4*BCD_DIGITS-1:0] adj;

   // add 3 to every nibble >= 5 before the shift
   always_comb begin
      adj = o_bcd;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
         if (o_bcd[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = o_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shreg  <= '0;
         step   <= '0;
         active <= 1'b0;
         o_bcd  <= '0;
      end else if (i_start) begin
         shreg  <= i_bin;
         step   <= '0;
         active <= 1'b1;
         o_bcd  <= '0;
      end else if (active) begin
         if (step == STEPS) begin
            active <= 1'b0;
         end else begin
            o_bcd <= {adj[4*BCD_DIGITS-2:0], shreg[DATA_WIDTH-1]};
            shreg <= shreg << 1;
            step  <= step + 1'b1;
         end
      end
   end

   assign o_last = active && (step == STEPS - 1'b1);
   assign o_done = active && (step == STEPS);

endmodule

// File: rtl/out_display.sv
// out_display: captures output-register writes, converts them to BCD and
// drives a four-digit time-multiplexed seven-segment display.
//   i_clk, i_reset_n  clock, asynchronous active-low reset
//   bus               out_display_if.slave: i_clke, i_load, i_data, o_busy
//   o_an              one-hot digit enable, bit 0 = least-significant digit
//   o_seg             segments gfedcba, active high
// Build option: OUT_SIGNED_EN treats i_data as two's complement and shows a
// minus sign on digit 3 for negative values.
module out_display
   import out_display_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SCAN_DIV   = 1024
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   out_display_if.slave    bus,
   output logic [3:0]      o_an,
   output logic [6:0]      o_seg
);
   localparam int unsigned SW = $clog2(SCAN_DIV);

   state_t                  state, state_nx;
   logic                    load, do_start, do_commit;
   logic                    pend_valid;
   logic [DATA_WIDTH-1:0]   pend_data, start_data, conv_mag;
   logic                    conv_last, conv_done;
   logic [4*BCD_DIGITS-1:0] bcd, disp_bcd;
   logic                    disp_neg;
   logic [SW-1:0]           scan_cnt;
   logic [1:0]              scan_idx;
   logic [3:0]              an_nx;
   logic [6:0]              seg_nx;
   logic [3:0]              d_ones, d_tens, d_hund;

   assign load = bus.i_load & bus.i_clke;
   // a load in the same cycle supersedes the pending value
   assign start_data = load ? bus.i_data : pend_data;

`ifdef OUT_SIGNED_EN
   logic start_neg, conv_neg;
   assign start_neg = start_data[DATA_WIDTH-1];
   assign conv_mag  = start_neg ? -start_data : start_data;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         conv_neg <= 1'b0;
         disp_neg <= 1'b0;
      end else begin
         if (do_start)  conv_neg <= start_neg;
         if (do_commit) disp_neg <= conv_neg;
      end
   end
`else
   assign conv_mag = start_data;
   assign disp_neg = 1'b0;
`endif

   bin2bcd_serial #(.DATA_WIDTH(DATA_WIDTH)) u_bin2bcd (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_start   (do_start),
      .i_bin     (conv_mag),
      .o_last    (conv_last),
      .o_done    (conv_done),
      .o_bcd     (bcd)
   );

   // FSM: state register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= IDLE;
      else            state <= state_nx;
   end

   // FSM: next state
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (load || pend_valid) state_nx = CONVERT;
         CONVERT: if (conv_last)          state_nx = COMMIT;
         COMMIT:                          state_nx = IDLE;
         default:                         state_nx = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      do_start   = (state == IDLE) && (load || pend_valid);
      do_commit  = (state == COMMIT) && conv_done;
      bus.o_busy = (state != IDLE) || pend_valid;
   end

   // one-deep pending register, newest write wins
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pend_valid <= 1'b0;
         pend_data  <= '0;
      end else if (load && (state != IDLE)) begin
         pend_valid <= 1'b1;
         pend_data  <= bus.i_data;
      end else if (do_start) begin
         pend_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)     disp_bcd <= '0;
      else if (do_commit) disp_bcd <= bcd;
   end

   // free-running scan, independent of i_clke
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         scan_cnt <= '0;
         scan_idx <= '0;
      end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
         scan_cnt <= '0;
         scan_idx <= scan_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign d_ones = disp_bcd[3:0];
   assign d_tens = disp_bcd[7:4];
   assign d_hund = disp_bcd[11:8];

   always_comb begin
      an_nx  = 4'b0001;
      seg_nx = seg_of_digit(d_ones);
      case (scan_idx)
         2'd1: begin
            an_nx  = 4'b0010;
            seg_nx = (d_hund == 4'd0 && d_tens == 4'd0) ? SEG_BLANK : seg_of_digit(d_tens);
         end
         2'd2: begin
            an_nx  = 4'b0100;
            seg_nx = (d_hund == 4'd0) ? SEG_BLANK : seg_of_digit(d_hund);
         end
         2'd3: begin
            an_nx  = 4'b1000;
            seg_nx = disp_neg ? SEG_MINUS : SEG_BLANK;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_an  <= 4'b0001;
         o_seg <= 7'h3F;
      end else begin
         o_an  <= an_nx;
         o_seg <= seg_nx;
      end
   end

endmodule

// File: tb/tb_out_display.sv
// tb_out_display: self-checking bench for out_display with a short scan
// period; expected digits come from decimal arithmetic on the written value.
module tb_out_display;
   localparam int unsigned DW       = 8;
   localparam int unsigned SCAN_DIV = 4;
   localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] o_an;
   logic [6:0] o_seg;
   int         checks = 0;
   int         errors = 0;

   out_display_if #(.DATA_WIDTH(DW)) bus ();

   out_display #(.DATA_WIDTH(DW), .SCAN_DIV(SCAN_DIV)) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus),
      .o_an      (o_an),
      .o_seg     (o_seg)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_seg(input logic [7:0] v, input logic [3:0] an);
      int unsigned mag;
      bit          neg;
      logic [7:0]  r;
      mag = v;
      neg = 1'b0;
`ifdef OUT_SIGNED_EN
      if (v >= 8'd128) begin
         neg = 1'b1;
         mag = 256 - v;
      end
`endif
      case (an)
         4'b0001: r = {1'b0, SEG_TAB[mag % 10]};
         4'b0010: r = (mag < 10)  ? 8'h00 : {1'b0, SEG_TAB[(mag / 10) % 10]};
         4'b0100: r = (mag < 100) ? 8'h00 : {1'b0, SEG_TAB[mag / 100]};
         4'b1000: r = neg ? 8'h40 : 8'h00;
         default: r = 8'hFF;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // samples every slot of a full scan and checks it against value v
   task automatic chk_disp(input logic [7:0] v, input string tag);
      logic [3:0] seen;
      seen = '0;
      repeat (4 * SCAN_DIV) begin
         @(negedge clk);
         chk(tag, {25'd0, o_seg}, {24'd0, exp_seg(v, o_an)});
         seen = seen | o_an;
      end
      chk({tag, "_cover"}, {28'd0, seen}, 32'hF);
   endtask

   // returns at the negedge right after the edge that sampled the load
   task automatic do_load(input logic [7:0] v);
      @(negedge clk);
      bus.i_load = 1'b1;
      bus.i_clke = 1'b1;
      bus.i_data = v;
      @(negedge clk);
      bus.i_load = 1'b0;
   endtask

   task automatic load_check(input logic [7:0] v);
      do_load(v);
      for (int k = 0; k <= DW; k++) begin
         chk("busy_hi", {31'd0, bus.o_busy}, 32'd1);
         @(negedge clk);
      end
      chk("busy_lo", {31'd0, bus.o_busy}, 32'd0);
      chk_disp(v, $sformatf("digits_%0d", v));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] v;
      logic [7:0] dir [9];
      dir = '{8'd123, 8'd7, 8'h80, 8'd0, 8'd255, 8'd10, 8'd100, 8'd9, 8'd99};

      rst_n      = 1'b0;
      bus.i_load = 1'b0;
      bus.i_clke = 1'b1;
      bus.i_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_an",   {28'd0, o_an}, 32'h1);
      chk("rst_seg",  {25'd0, o_seg}, 32'h3F);
      chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_an",  {28'd0, o_an}, 32'h1);
      chk("post_rst_seg", {25'd0, o_seg}, 32'h3F);
      chk_disp(8'd0, "rst_digits");

      foreach (dir[i]) load_check(dir[i]);
      repeat (8) begin
         v = 8'($urandom_range(0, 255));
         load_check(v);
      end

      // back-to-back loads: 200 converts, 45 is overwritten by 99 while pending
      @(negedge clk);
      bus.i_load = 1'b1;
      bus.i_data = 8'd200;
      @(negedge clk);
      bus.i_data = 8'd45;
      @(negedge clk);
      bus.i_data = 8'd99;
      @(negedge clk);
      bus.i_load = 1'b0;
      for (int t = 2; t <= 19; t++) begin
         chk("coal_busy", {31'd0, bus.o_busy}, (t <= 18) ? 32'd1 : 32'd0);
         if (t >= 10)
            chk("coal_200", {25'd0, o_seg}, {24'd0, exp_seg(8'd200, o_an)});
         @(negedge clk);
      end
      chk_disp(8'd99, "coal_99");

      // load without clock enable is ignored
      bus.i_load = 1'b1;
      bus.i_clke = 1'b0;
      bus.i_data = 8'd55;
      repeat (3) begin
         @(negedge clk);
         chk("clke_busy", {31'd0, bus.o_busy}, 32'd0);
      end
      bus.i_load = 1'b0;
      bus.i_clke = 1'b1;
      chk_disp(8'd99, "clke_digits");

      // reset during the fourth CONVERT cycle
      load_check(8'd58);
      do_load(8'd173);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_an",   {28'd0, o_an}, 32'h1);
      chk("abort_seg",  {25'd0, o_seg}, 32'h3F);
      chk("abort_busy", {31'd0, bus.o_busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_busy2", {31'd0, bus.o_busy}, 32'd0);
      chk_disp(8'd0, "abort_digits");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
